// File: rtl/uart_rx_oversampled_if.sv
// Receiver-side bundle for uart_rx_oversampled: line, configuration and delivered status.
// RX_BREAK_DETECT_EN adds break_detected.
interface uart_rx_oversampled_if;
   logic [1:0] baud_sel;
   logic [4:0] line_control_reg;
   logic       serial_in;
   logic [7:0] data_received;
   logic       data_valid;
   logic       parity_error;
   logic       framing_error;
   logic       active_flag_rx;
`ifdef RX_BREAK_DETECT_EN
   logic       break_detected;
`endif

   modport master (
      output baud_sel, line_control_reg, serial_in,
      input  data_received, data_valid, parity_error, framing_error, active_flag_rx
`ifdef RX_BREAK_DETECT_EN
      , input break_detected
`endif
   );

   modport slave (
      input  baud_sel, line_control_reg, serial_in,
      output data_received, data_valid, parity_error, framing_error, active_flag_rx
`ifdef RX_BREAK_DETECT_EN
      , output break_detected
`endif
   );
endinterface

// File: rtl/uart_rx_oversampled.sv
// 16x-oversampled UART receiver, 3-sample majority vote per bit, parity/framing status.
// Define RX_BREAK_DETECT_EN to add break_detected and the break-wait state.
module uart_rx_oversampled #(
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   uart_rx_oversampled_if.slave rx
);

   function automatic int unsigned div_for(input int unsigned baud);
      return (CLK_FREQ + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
   endfunction

   localparam int unsigned DIV0  = div_for(2400);
   localparam int unsigned DIV1  = div_for(4800);
   localparam int unsigned DIV2  = div_for(9600);
   localparam int unsigned DIV3  = div_for(19200);
   localparam int unsigned CNT_W = (DIV0 > 1) ? $clog2(DIV0) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_STOP2, S_BREAK
   } state_t;

   state_t           r_state, w_next;
   logic             r_sync1, r_sync2, r_line_prev;
   logic             w_line, w_start_edge;
   logic [CNT_W-1:0] r_clk_cnt, w_div_m1, w_div_half;
   logic [3:0]       r_tick;
   logic [1:0]       r_baud;
   logic [4:0]       r_lcr;
   logic [2:0]       r_bit_cnt;
   logic [7:0]       r_shift;
   logic             r_par, r_pe, r_fe, r_s7, r_s8;
   logic             w_tick_end, w_mid, w_vote_pt, w_vote, w_last_bit;
   logic             w_deliver, w_brk_frame, w_brk_hold;
   logic [7:0]       r_data;
   logic             r_valid, r_pe_out, r_fe_out;

   assign w_line       = r_sync2;
   assign w_start_edge = r_line_prev & ~r_sync2;

   always_comb begin
      w_div_m1   = CNT_W'(DIV2 - 1);
      w_div_half = CNT_W'(DIV2 / 2);
      unique case (r_baud)
         2'b00: begin w_div_m1 = CNT_W'(DIV0 - 1); w_div_half = CNT_W'(DIV0 / 2); end
         2'b01: begin w_div_m1 = CNT_W'(DIV1 - 1); w_div_half = CNT_W'(DIV1 / 2); end
         2'b10: begin w_div_m1 = CNT_W'(DIV2 - 1); w_div_half = CNT_W'(DIV2 / 2); end
         2'b11: begin w_div_m1 = CNT_W'(DIV3 - 1); w_div_half = CNT_W'(DIV3 / 2); end
      endcase
   end

   // Samples are taken mid-tick at ticks 7 and 8; the vote is formed at tick 9.
   assign w_tick_end = (r_clk_cnt == w_div_m1);
   assign w_mid      = (r_clk_cnt == w_div_half);
   assign w_vote_pt  = w_mid && (r_tick == 4'd9);
   assign w_vote     = (r_s7 & r_s8) | (r_s7 & w_line) | (r_s8 & w_line);
   assign w_last_bit = (r_bit_cnt == {1'b1, r_lcr[1:0]});
   assign w_brk_hold = (r_state == S_BREAK) && !w_line;

`ifdef RX_BREAK_DETECT_EN
   logic r_zero, r_brk_pend, r_brk;
   assign w_brk_frame       = (r_state == S_STOP2) ? r_brk_pend : (r_zero & ~w_vote);
   assign rx.break_detected = r_brk;
`else
   assign w_brk_frame = 1'b0;
`endif

   always_comb begin
      w_next    = r_state;
      w_deliver = 1'b0;
      unique case (r_state)
         S_IDLE:   if (w_start_edge) w_next = S_START;
         S_START:  if (w_vote_pt) w_next = w_vote ? S_IDLE : S_DATA;
         S_DATA:   if (w_vote_pt && w_last_bit) w_next = r_lcr[3] ? S_PARITY : S_STOP;
         S_PARITY: if (w_vote_pt) w_next = S_STOP;
         S_STOP: begin
            if (w_vote_pt) begin
               if (r_lcr[2]) begin
                  w_next = S_STOP2;
               end else begin
                  w_deliver = 1'b1;
                  w_next    = w_brk_frame ? S_BREAK : S_IDLE;
               end
            end
         end
         S_STOP2: begin
            if (w_vote_pt) begin
               w_deliver = 1'b1;
               w_next    = w_brk_frame ? S_BREAK : S_IDLE;
            end
         end
         S_BREAK:  if (w_line && w_tick_end && (r_tick == 4'd15)) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1     <= 1'b1;
         r_sync2     <= 1'b1;
         r_line_prev <= 1'b1;
         r_state     <= S_IDLE;
      end else begin
         r_sync1     <= rx.serial_in;
         r_sync2     <= r_sync1;
         r_line_prev <= r_sync2;
         r_state     <= w_next;
      end
   end

   // Break wait restarts the bit timer on every low sample so only a full high bit clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_clk_cnt <= '0;
         r_tick    <= '0;
      end else if ((r_state == S_IDLE) || w_brk_hold) begin
         r_clk_cnt <= '0;
         r_tick    <= '0;
      end else if (w_tick_end) begin
         r_clk_cnt <= '0;
         r_tick    <= r_tick + 1'b1;
      end else begin
         r_clk_cnt <= r_clk_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s7      <= 1'b1;
         r_s8      <= 1'b1;
         r_baud    <= '0;
         r_lcr     <= '0;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_par     <= 1'b0;
         r_pe      <= 1'b0;
         r_fe      <= 1'b0;
      end else begin
         if (w_mid && (r_tick == 4'd7)) r_s7 <= w_line;
         if (w_mid && (r_tick == 4'd8)) r_s8 <= w_line;
         if ((r_state == S_IDLE) && w_start_edge) begin
            r_baud    <= rx.baud_sel;
            r_lcr     <= rx.line_control_reg;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_par     <= 1'b0;
            r_pe      <= 1'b0;
            r_fe      <= 1'b0;
         end else if (w_vote_pt) begin
            if (r_state == S_DATA) begin
               r_shift[r_bit_cnt] <= w_vote;
               r_bit_cnt          <= r_bit_cnt + 1'b1;
               r_par              <= r_par ^ w_vote;
            end
            if (r_state == S_PARITY) r_pe <= r_par ^ w_vote ^ ~r_lcr[4];
            if (((r_state == S_STOP) || (r_state == S_STOP2)) && !w_vote) r_fe <= 1'b1;
         end
      end
   end

`ifdef RX_BREAK_DETECT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_zero     <= 1'b0;
         r_brk_pend <= 1'b0;
         r_brk      <= 1'b0;
      end else begin
         if ((r_state == S_IDLE) && w_start_edge) begin
            r_zero <= 1'b1;
         end else if (w_vote_pt && w_vote && ((r_state == S_DATA) || (r_state == S_PARITY))) begin
            r_zero <= 1'b0;
         end
         if (w_vote_pt && (r_state == S_STOP)) r_brk_pend <= r_zero & ~w_vote;
         if (w_deliver) begin
            r_brk <= w_brk_frame;
         end else if ((r_state == S_BREAK) && (w_next == S_IDLE)) begin
            r_brk <= 1'b0;
         end
      end
   end
`endif

   // The final stop vote is folded in directly since r_fe has not captured it yet.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data   <= '0;
         r_valid  <= 1'b0;
         r_pe_out <= 1'b0;
         r_fe_out <= 1'b0;
      end else begin
         r_valid <= w_deliver;
         if (w_deliver) begin
            r_data   <= r_shift;
            r_pe_out <= r_pe;
            r_fe_out <= r_fe | ~w_vote;
         end
      end
   end

   assign rx.data_received  = r_data;
   assign rx.data_valid     = r_valid;
   assign rx.parity_error   = r_pe_out;
   assign rx.framing_error  = r_fe_out;
   assign rx.active_flag_rx = (r_state == S_DATA) || (r_state == S_PARITY) ||
                              (r_state == S_STOP) || (r_state == S_STOP2);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Self-checking bench for uart_rx_oversampled: frames driven bit-by-bit, compared to a frame-level model.
// Build with RX_BREAK_DETECT_EN to also check break_detected.
`timescale 1ns/1ps
module tb_uart_rx_oversampled;
   localparam int unsigned CLK_FREQ = 614_400;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
      logic       brk;
   } rec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_rx_oversampled_if rx_if();

   uart_rx_oversampled #(.CLK_FREQ(CLK_FREQ), .OVERSAMPLE(16)) dut (
      .clk (clk),
      .rst (rst),
      .rx  (rx_if)
   );

   int          total = 0;
   int          bad   = 0;
   int unsigned cyc   = 0;
   int unsigned last_cyc = 0;
   int unsigned active_cnt = 0;
   rec_t        got[$];
   logic        brk_now;

`ifdef RX_BREAK_DETECT_EN
   assign brk_now = rx_if.break_detected;
`else
   assign brk_now = 1'b0;
`endif

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_if.active_flag_rx) active_cnt = active_cnt + 1;
      if (!rst && rx_if.data_valid) begin
         got.push_back(rec_t'({rx_if.data_received, rx_if.parity_error, rx_if.framing_error, brk_now}));
         last_cyc = cyc;
      end
   end

   function automatic int unsigned bit_clks(input logic [1:0] b);
      int unsigned baud;
      baud = 2400 << b;
      return 16 * ((CLK_FREQ + 8 * baud) / (16 * baud));
   endfunction

   function automatic logic [7:0] masked(input logic [4:0] lcr, input logic [7:0] d);
      int unsigned n;
      n = 5 + lcr[1:0];
      return d & 8'((1 << n) - 1);
   endfunction

   function automatic logic good_par(input logic [4:0] lcr, input logic [7:0] d);
      int unsigned ones;
      ones = $countones(masked(lcr, d));
      return lcr[4] ? logic'(ones % 2) : logic'(1 - ones % 2);
   endfunction

   // Expected status computed from the frame contents alone.
   function automatic rec_t model(input logic [4:0] lcr, input logic [7:0] d, input logic pbit,
                                  input logic s1, input logic s2);
      rec_t        r;
      int unsigned ones;
      r.d  = masked(lcr, d);
      ones = $countones(r.d);
      if (lcr[3] && pbit) ones++;
      r.pe = lcr[3] && ((ones % 2) != (lcr[4] ? 0 : 1));
      r.fe = !s1 || (lcr[2] && !s2);
`ifdef RX_BREAK_DETECT_EN
      r.brk = (r.d == 8'h00) && !(lcr[3] && pbit) && !s1;
`else
      r.brk = 1'b0;
`endif
      return r;
   endfunction

   task automatic drive_bit(input logic v, input int unsigned clks);
      rx_if.serial_in = v;
      repeat (clks) @(negedge clk);
   endtask

   task automatic send_frame(input logic [1:0] b, input logic [4:0] lcr, input logic [7:0] d,
                             input logic pbit, input logic s1, input logic s2, input logic scramble);
      int unsigned bt;
      bt = bit_clks(b);
      rx_if.baud_sel         = b;
      rx_if.line_control_reg = lcr;
      drive_bit(1'b0, bt);
      if (scramble) begin
         rx_if.baud_sel         = 2'($urandom);
         rx_if.line_control_reg = 5'($urandom);
      end
      for (int i = 0; i < 5 + int'(lcr[1:0]); i++) drive_bit(d[i], bt);
      if (lcr[3]) drive_bit(pbit, bt);
      drive_bit(s1, bt);
      if (lcr[2]) drive_bit(s2, bt);
      rx_if.serial_in = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rx_if.serial_in        = 1'b1;
      rx_if.baud_sel         = 2'b10;
      rx_if.line_control_reg = 5'b00011;
      repeat (3) @(negedge clk);
      total++;
      if (rx_if.data_received !== 8'h00) begin
         bad++; $display("FAIL reset_data got=%h exp=00", rx_if.data_received);
      end
      total++;
      if ({rx_if.data_valid, rx_if.parity_error, rx_if.framing_error, rx_if.active_flag_rx, brk_now} !== 5'b0) begin
         bad++; $display("FAIL reset_flags got=%b exp=00000",
            {rx_if.data_valid, rx_if.parity_error, rx_if.framing_error, rx_if.active_flag_rx, brk_now});
      end
      rst = 1'b0;
      repeat (2 * bit_clks(2)) @(negedge clk);
      total++;
      if (got.size() != 0 || active_cnt != 0) begin
         bad++; $display("FAIL reset_idle strobes=%0d active=%0d exp=0,0", got.size(), active_cnt);
      end
   endtask

   task automatic test_8n1_latency();
      int unsigned n0, a0, t0, bt, lat;
      rec_t        e;
      bt = bit_clks(2);
      n0 = got.size(); a0 = active_cnt; t0 = cyc;
      send_frame(2'b10, 5'b00011, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
      e = model(5'b00011, 8'hA5, 1'b0, 1'b1, 1'b1);
      repeat (bt) @(negedge clk);
      total++;
      if (got.size() != n0 + 1 || got[n0] !== e) begin
         bad++; $display("FAIL 8n1_rec n=%0d got=%h exp=%h", got.size() - n0, got[n0], e);
      end
      lat = last_cyc - t0;
      total++;
      if (lat <= 9 * bt || lat >= 10 * bt) begin
         bad++; $display("FAIL 8n1_latency got=%0d exp=(%0d,%0d)", lat, 9 * bt, 10 * bt);
      end
      total++;
      if (active_cnt == a0 || rx_if.active_flag_rx !== 1'b0) begin
         bad++; $display("FAIL 8n1_active cycles=%0d now=%b exp=>0,0", active_cnt - a0, rx_if.active_flag_rx);
      end
      total++;
      if (rx_if.data_received !== 8'hA5 || rx_if.data_valid !== 1'b0) begin
         bad++; $display("FAIL 8n1_hold got=%h/%b exp=a5/0", rx_if.data_received, rx_if.data_valid);
      end
   endtask

   task automatic test_parity();
      logic [4:0] lcr_t[4] = '{5'b11010, 5'b11010, 5'b01010, 5'b01010};
      logic       flip_t[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int unsigned n0;
      logic        pbit;
      rec_t        e;
      for (int i = 0; i < 4; i++) begin
         n0   = got.size();
         pbit = good_par(lcr_t[i], 8'h35) ^ flip_t[i];
         send_frame(2'b11, lcr_t[i], 8'h35, pbit, 1'b1, 1'b1, 1'b0);
         e = model(lcr_t[i], 8'h35, pbit, 1'b1, 1'b1);
         repeat (bit_clks(2'b11)) @(negedge clk);
         total++;
         if (got.size() != n0 + 1 || got[n0] !== e) begin
            bad++; $display("FAIL parity_%0d got=%h exp=%h", i, got[n0], e);
         end
      end
   endtask

   task automatic test_framing();
      logic [7:0] d_t[3]  = '{8'h3C, 8'h3C, 8'hC3};
      logic       s1_t[3] = '{1'b1, 1'b0, 1'b1};
      logic       s2_t[3] = '{1'b0, 1'b1, 1'b1};
      int unsigned n0;
      rec_t        e;
      for (int i = 0; i < 3; i++) begin
         n0 = got.size();
         send_frame(2'b00, 5'b00111, d_t[i], 1'b0, s1_t[i], s2_t[i], 1'b0);
         e = model(5'b00111, d_t[i], 1'b0, s1_t[i], s2_t[i]);
         repeat (bit_clks(2'b00)) @(negedge clk);
         total++;
         if (got.size() != n0 + 1 || got[n0] !== e) begin
            bad++; $display("FAIL framing_%0d got=%h exp=%h", i, got[n0], e);
         end
         total++;
         if (rx_if.framing_error !== e.fe) begin
            bad++; $display("FAIL framing_hold_%0d got=%b exp=%b", i, rx_if.framing_error, e.fe);
         end
      end
   endtask

   task automatic test_glitch();
      int unsigned glen_t[2] = '{4, 20};
      int unsigned n0, a0;
      rx_if.baud_sel = 2'b10;
      for (int i = 0; i < 2; i++) begin
         n0 = got.size(); a0 = active_cnt;
         drive_bit(1'b0, glen_t[i]);
         drive_bit(1'b1, 2 * bit_clks(2'b10));
         total++;
         if (got.size() != n0 || active_cnt != a0) begin
            bad++; $display("FAIL glitch_%0d strobes=%0d active=%0d exp=0,0", i, got.size() - n0, active_cnt - a0);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d_t[3] = '{8'h00, 8'hFF, 8'h55};
      int unsigned n0;
      rec_t        e;
      n0 = got.size();
      for (int i = 0; i < 3; i++) send_frame(2'b10, 5'b00011, d_t[i], 1'b0, 1'b1, 1'b1, 1'b0);
      repeat (bit_clks(2'b10)) @(negedge clk);
      total++;
      if (got.size() != n0 + 3) begin
         bad++; $display("FAIL b2b_count got=%0d exp=3", got.size() - n0);
      end
      for (int i = 0; i < 3; i++) begin
         e = model(5'b00011, d_t[i], 1'b0, 1'b1, 1'b1);
         total++;
         if (got.size() <= n0 + i || got[n0 + i] !== e) begin
            bad++; $display("FAIL b2b_rec%0d got=%h exp=%h", i, got[n0 + i], e);
         end
      end
   endtask

   task automatic test_reset_midframe();
      int unsigned n0, bt;
      logic [7:0]  d;
      rec_t        e;
      bt = bit_clks(2'b10);
      d  = 8'h5A;
      n0 = got.size();
      rx_if.baud_sel = 2'b10; rx_if.line_control_reg = 5'b00011;
      drive_bit(1'b0, bt);
      for (int i = 0; i < 4; i++) drive_bit(d[i], bt);
      drive_bit(d[4], bt / 2);
      total++;
      if (rx_if.active_flag_rx !== 1'b1) begin
         bad++; $display("FAIL midrst_active got=%b exp=1", rx_if.active_flag_rx);
      end
      rst = 1'b1;
      rx_if.serial_in = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({rx_if.data_received, rx_if.data_valid, rx_if.parity_error, rx_if.framing_error,
           rx_if.active_flag_rx, brk_now} !== 13'h0) begin
         bad++; $display("FAIL midrst_outputs got=%h/%b%b%b%b%b exp=00/00000", rx_if.data_received,
            rx_if.data_valid, rx_if.parity_error, rx_if.framing_error, rx_if.active_flag_rx, brk_now);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2 * bt) @(negedge clk);
      total++;
      if (got.size() != n0) begin
         bad++; $display("FAIL midrst_nostrobe got=%0d exp=0", got.size() - n0);
      end
      send_frame(2'b10, 5'b00011, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0);
      e = model(5'b00011, 8'h81, 1'b0, 1'b1, 1'b1);
      repeat (bt) @(negedge clk);
      total++;
      if (got.size() != n0 + 1 || got[n0] !== e) begin
         bad++; $display("FAIL midrst_next got=%h exp=%h", got[n0], e);
      end
   endtask

   task automatic test_line_low();
      int unsigned n0, bt;
      rec_t        e;
      bt = bit_clks(2'b10);
      n0 = got.size();
      rx_if.baud_sel = 2'b10; rx_if.line_control_reg = 5'b00011;
      drive_bit(1'b0, 20 * bt);
      e = model(5'b00011, 8'h00, 1'b0, 1'b0, 1'b0);
      total++;
      if (got.size() != n0 + 1 || got[n0] !== e) begin
         bad++; $display("FAIL low_rec n=%0d got=%h exp=%h", got.size() - n0, got[n0], e);
      end
      total++;
      if (rx_if.active_flag_rx !== 1'b0) begin
         bad++; $display("FAIL low_retrigger active=%b exp=0", rx_if.active_flag_rx);
      end
`ifdef RX_BREAK_DETECT_EN
      total++;
      if (rx_if.break_detected !== 1'b1) begin
         bad++; $display("FAIL brk_set got=%b exp=1", rx_if.break_detected);
      end
      drive_bit(1'b1, bt / 2);
      total++;
      if (rx_if.break_detected !== 1'b1) begin
         bad++; $display("FAIL brk_hold got=%b exp=1", rx_if.break_detected);
      end
      drive_bit(1'b1, bt);
      total++;
      if (rx_if.break_detected !== 1'b0) begin
         bad++; $display("FAIL brk_clear got=%b exp=0", rx_if.break_detected);
      end
`else
      drive_bit(1'b1, 2 * bt);
`endif
      n0 = got.size();
      send_frame(2'b10, 5'b00011, 8'h96, 1'b0, 1'b1, 1'b1, 1'b0);
      e = model(5'b00011, 8'h96, 1'b0, 1'b1, 1'b1);
      repeat (bt) @(negedge clk);
      total++;
      if (got.size() != n0 + 1 || got[n0] !== e) begin
         bad++; $display("FAIL low_recover got=%h exp=%h", got[n0], e);
      end
   endtask

   task automatic test_random();
      int unsigned n0, bt;
      logic [1:0]  b;
      logic [4:0]  lcr;
      logic [7:0]  d;
      logic        pbit;
      rec_t        e;
      for (int i = 0; i < 12; i++) begin
         b    = 2'($urandom);
         lcr  = 5'($urandom);
         d    = 8'($urandom);
         pbit = good_par(lcr, d) ^ ($urandom_range(0, 2) == 0);
         bt   = bit_clks(b);
         n0   = got.size();
         send_frame(b, lcr, d, pbit, 1'b1, 1'b1, 1'b1);
         e = model(lcr, d, pbit, 1'b1, 1'b1);
         repeat (4 + $urandom_range(0, bt)) @(negedge clk);
         total++;
         if (got.size() != n0 + 1 || got[n0] !== e) begin
            bad++; $display("FAIL random_%0d b=%0d lcr=%b d=%h got=%h exp=%h", i, b, lcr, d, got[n0], e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_8n1_latency();
      test_parity();
      test_framing();
      test_glitch();
      test_back_to_back();
      test_reset_midframe();
      test_line_low();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
